// File: rtl/march_bist_seq_if.sv
// March BIST sequencer bus: gray address counter enable/address plus the memory-under-test port.
// Ports: cnt_en/cnt_addr to/from the gray counter; mem_cs/mem_we/mem_addr/mem_wdata to the
//        memory, mem_rdata back (valid the cycle after a read strobe). master = sequencer side.
interface march_bist_seq_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              cnt_en;
   logic [ADDR_W-1:0] cnt_addr;
   logic              mem_cs;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output cnt_en,
      input  cnt_addr,
      output mem_cs,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  cnt_en,
      output cnt_addr,
      input  mem_cs,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/march_bist_seq.sv
// March C- BIST sequencer: steps six elements over a gray address counter, issues r/w ops, logs fails.
// Latency: op1 strobes one cycle after a slot start, read compared one cycle after its strobe,
//          op2 two cycles after op1. No backpressure: the counter paces slots; a slot that is cut
//          short drops its pending op and raises err_timing.
// Ports: clk, rst (async, active high), start; status busy/done/fail/fail_addr/fail_elem/
//        fail_cnt/err_timing; bus = counter + memory interface (master side).
module march_bist_seq #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [FCNT_W-1:0] fail_cnt,
   output logic              err_timing,
   march_bist_seq_if.master  bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_FIN} state_t;

   localparam logic [ADDR_W:0]   SLOTS   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] MSB     = {1'b1, {(ADDR_W-1){1'b0}}};
   localparam logic [1:0]        PH_IDLE = 2'd3;

   state_t            state, state_nxt;
   logic [2:0]        elem;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] slot_addr;
   logic [ADDR_W:0]   slot_cnt;
   logic [1:0]        ph;          // cycle within the current slot; PH_IDLE = no slot active

   logic              mem_cs_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              chk_vld, chk_bg;
   logic [ADDR_W-1:0] chk_addr;
   logic [2:0]        chk_elem;

   logic              in_run, chg, slot_new, elem_end, op2_go, mismatch;
   logic              is_dn, has_op2, rd_bg, wr2_bg;
   logic [ADDR_W-1:0] cur_addr;

   // element decode: E0 w0 | E1 r0,w1 | E2 r1,w0 | E3 dn r0,w1 | E4 dn r1,w0 | E5 r0
   always_comb begin
      is_dn   = (elem == 3'd3) || (elem == 3'd4);
      has_op2 = (elem >= 3'd1) && (elem <= 3'd4);
      rd_bg   = (elem == 3'd2) || (elem == 3'd4);
      wr2_bg  = (elem == 3'd1) || (elem == 3'd3);
   end

   // A slot begins on RUN entry (no slots counted yet) or whenever the counter moves. The move
   // that follows the last slot is the wrap back to 0 and ends the element instead.
   always_comb begin
      in_run   = (state == S_RUN);
      chg      = (bus.cnt_addr != addr_q);
      slot_new = in_run && ((slot_cnt == '0) || (chg && (slot_cnt != SLOTS)));
      elem_end = in_run && chg && (slot_cnt == SLOTS);
      // flipping the MSB of a reflected Gray code walks the up sequence backwards
      cur_addr = is_dn ? (bus.cnt_addr ^ MSB) : bus.cnt_addr;
      op2_go   = in_run && (ph == 2'd1) && has_op2 && !slot_new && !elem_end;
      mismatch = chk_vld && (bus.mem_rdata != {DATA_W{chk_bg}});
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (elem_end) state_nxt = S_GAP;
         S_GAP:   state_nxt = (elem == 3'd5) ? S_FIN : S_RUN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs, decoded from the state register so they change only on clock edges.
   // GAP drops cnt_en for a cycle so the counter restarts its prescale for the next element.
   always_comb begin
      bus.cnt_en = (state == S_RUN);
      busy       = (state == S_RUN) || (state == S_GAP);
      done       = (state == S_FIN);
   end

   assign bus.mem_cs    = mem_cs_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem        <= '0;
         addr_q      <= '0;
         slot_addr   <= '0;
         slot_cnt    <= '0;
         ph          <= PH_IDLE;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         chk_vld     <= 1'b0;
         chk_bg      <= 1'b0;
         chk_addr    <= '0;
         chk_elem    <= '0;
         fail        <= 1'b0;
         fail_addr   <= '0;
         fail_elem   <= '0;
         fail_cnt    <= '0;
         err_timing  <= 1'b0;
      end else begin
         // tracked in every state so a stale copy never fakes a slot on RUN entry
         addr_q   <= bus.cnt_addr;
         mem_cs_q <= 1'b0;

         // a new slot preempts any op2 still waiting in the old one
         if (slot_new) begin
            mem_cs_q    <= 1'b1;
            mem_we_q    <= (elem == 3'd0);
            mem_addr_q  <= cur_addr;
            mem_wdata_q <= '0;
            slot_addr   <= cur_addr;
         end else if (op2_go) begin
            mem_cs_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= slot_addr;
            mem_wdata_q <= {DATA_W{wr2_bg}};
         end

         if (slot_new)               ph <= 2'd0;
         else if (!in_run || elem_end) ph <= PH_IDLE;
         else if (ph != PH_IDLE)     ph <= ph + 2'd1;

         if (!in_run)       slot_cnt <= '0;
         else if (slot_new) slot_cnt <= slot_cnt + 1'b1;

         if ((state == S_GAP) && (elem != 3'd5)) elem <= elem + 3'd1;

         // op2 not yet on the bus when its slot ends
         if ((slot_new || elem_end) && (ph < 2'd2) && has_op2) err_timing <= 1'b1;

         // read data returns the cycle after the strobe; capture what it must be checked against
         chk_vld  <= mem_cs_q & ~mem_we_q;
         chk_addr <= mem_addr_q;
         chk_bg   <= rd_bg;
         chk_elem <= elem;

         if (mismatch) begin
            if (!fail) begin
               fail      <= 1'b1;
               fail_addr <= chk_addr;
               fail_elem <= chk_elem;
            end
            if (fail_cnt != {FCNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
         end

         if ((state == S_IDLE) && start) begin
            elem       <= '0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_cnt   <= '0;
            err_timing <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_march_bist_seq.sv
// Bench for march_bist_seq: behavioural gray counter + memory models, directed March C- runs.
// Instance a: ADDR_W=3, DATA_W=8, FCNT_W=8 (cases 1-5). Instance b: FCNT_W=1 with address 0
// always reading 0xFF (case 6).
module tb_march_bist_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, start_b;

   logic       busy, done, fail, err_timing;
   logic [2:0] fail_addr, fail_elem;
   logic [7:0] fail_cnt;

   logic       busy_b, done_b, fail_b, err_b;
   logic [2:0] fail_addr_b, fail_elem_b;
   logic [0:0] fail_cnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   march_bist_seq_if #(.ADDR_W(3), .DATA_W(8)) bus_a ();
   march_bist_seq_if #(.ADDR_W(3), .DATA_W(8)) bus_b ();

   march_bist_seq #(.ADDR_W(3), .DATA_W(8), .FCNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_elem  (fail_elem),
      .fail_cnt   (fail_cnt),
      .err_timing (err_timing),
      .bus        (bus_a)
   );

   march_bist_seq #(.ADDR_W(3), .DATA_W(8), .FCNT_W(1)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .busy       (busy_b),
      .done       (done_b),
      .fail       (fail_b),
      .fail_addr  (fail_addr_b),
      .fail_elem  (fail_elem_b),
      .fail_cnt   (fail_cnt_b),
      .err_timing (err_b),
      .bus        (bus_b)
   );

   // gray counters: first step after per+1 enabled cycles, then every per cycles
   int         per;
   int         pre_a, pre_b;
   logic       frst_a, frst_b;
   logic [2:0] bin_a, bin_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_a <= 3'd0; pre_a <= 0; frst_a <= 1'b1;
      end else if (!bus_a.cnt_en) begin
         pre_a <= 0; frst_a <= 1'b1;
      end else if (pre_a == (frst_a ? per : per - 1)) begin
         pre_a <= 0; frst_a <= 1'b0; bin_a <= bin_a + 3'd1;
      end else begin
         pre_a <= pre_a + 1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_b <= 3'd0; pre_b <= 0; frst_b <= 1'b1;
      end else if (!bus_b.cnt_en) begin
         pre_b <= 0; frst_b <= 1'b1;
      end else if (pre_b == (frst_b ? 4 : 3)) begin
         pre_b <= 0; frst_b <= 1'b0; bin_b <= bin_b + 3'd1;
      end else begin
         pre_b <= pre_b + 1;
      end
   end

   assign bus_a.cnt_addr = bin_a ^ (bin_a >> 1);
   assign bus_b.cnt_addr = bin_b ^ (bin_b >> 1);

   // memories: flt=1 makes bit0 of address 6 stuck at 0 in instance a
   int         flt;
   logic [7:0] mem_a [8];
   logic [7:0] mem_b [8];

   always @(posedge clk) begin
      if (bus_a.mem_cs) begin
         if (bus_a.mem_we)
            mem_a[bus_a.mem_addr] <= (flt == 1 && bus_a.mem_addr == 3'd6) ?
                                     (bus_a.mem_wdata & 8'hFE) : bus_a.mem_wdata;
         else
            bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
      end
   end

   always @(posedge clk) begin
      if (bus_b.mem_cs) begin
         if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
         else bus_b.mem_rdata <= (bus_b.mem_addr == 3'd0) ? 8'hFF : mem_b[bus_b.mem_addr];
      end
   end

   // bus monitor for instance a
   logic       mon_clr;
   int         n_cs, n_wr, n_done;
   logic [2:0] rec_addr [128];
   logic       rec_we   [128];

   always @(negedge clk) begin
      if (mon_clr) begin
         n_cs <= 0; n_wr <= 0; n_done <= 0;
      end else begin
         if (bus_a.mem_cs) begin
            if (n_cs < 128) begin
               rec_addr[n_cs] <= bus_a.mem_addr;
               rec_we[n_cs]   <= bus_a.mem_we;
            end
            n_cs <= n_cs + 1;
            if (bus_a.mem_we) n_wr <= n_wr + 1;
         end
         if (done) n_done <= n_done + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // eight recorded addresses starting at index base, spaced by step, first one in the MSBs
   function automatic logic [23:0] seq(input int base, input int step);
      logic [23:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[20:0], rec_addr[base + i*step]};
      return v;
   endfunction

   task automatic clear_mon;
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic start_a;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // returns at the falling edge of the done cycle
   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; start_b = 1'b0; per = 4; flt = 0; mon_clr = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_a", {busy, done, fail, fail_addr, fail_elem, fail_cnt, err_timing,
                        bus_a.cnt_en, bus_a.mem_cs, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}, 32'd0);
      check("reset_b", 32'({busy_b, done_b, fail_b, fail_addr_b, fail_elem_b, fail_cnt_b, err_b,
                            bus_b.cnt_en, bus_b.mem_cs}), 32'd0);
      rst = 1'b0;
      clear_mon();

      // 1: fault-free run
      start_a();
      repeat (20) @(negedge clk);
      check("t1_busy", 32'(busy), 32'd1);
      wait_done("t1_done_seen");
      repeat (5) @(negedge clk);
      check("t1_strobes", n_cs, 32'd80);
      check("t1_writes", n_wr, 32'd40);
      check("t1_e0_addr", 32'(seq(0, 1)), 32'o01326754);
      check("t1_e0_we", 32'({rec_we[0], rec_we[7]}), 32'd3);
      check("t1_e3_addr", 32'(seq(40, 2)), 32'o45762310);
      check("t1_e3_rw", 32'({rec_we[40], rec_we[41]}), 32'd1);
      check("t1_done_cnt", n_done, 32'd1);
      check("t1_flags", 32'({fail, err_timing, busy}), 32'd0);

      // 2: bit0 of address 6 stuck at 0
      flt = 1;
      clear_mon();
      start_a();
      wait_done("t2_done_seen");
      @(negedge clk);
      check("t2_fail", 32'(fail), 32'd1);
      check("t2_fail_elem", 32'(fail_elem), 32'd2);
      check("t2_fail_addr", 32'(fail_addr), 32'd6);
      check("t2_fail_cnt", 32'(fail_cnt), 32'd2);
      check("t2_err", 32'(err_timing), 32'd0);

      // 3: counter steps every 2 cycles, op2 mostly squeezed out
      flt = 0; per = 2;
      clear_mon();
      start_a();
      wait_done("t3_done_seen");
      repeat (3) @(negedge clk);
      check("t3_err", 32'(err_timing), 32'd1);
      check("t3_strobes", n_cs, 32'd52);
      check("t3_writes", n_wr, 32'd12);
      check("t3_done_cnt", n_done, 32'd1);
      per = 4;

      // 4: reset in the middle of E3, then a clean rerun
      flt = 1;
      clear_mon();
      start_a();
      for (int i = 0; i < 2000 && n_cs < 45; i++) @(negedge clk);
      check("t4_reach_e3", 32'(n_cs >= 45), 32'd1);
      check("t4_fail_pre", 32'(fail), 32'd1);
      @(negedge clk); rst = 1'b1;
      #1;
      check("t4_reset_outs", {busy, done, fail, fail_addr, fail_elem, fail_cnt, err_timing,
                              bus_a.cnt_en, bus_a.mem_cs, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}, 32'd0);
      @(negedge clk); rst = 1'b0;
      check("t4_no_done", n_done, 32'd0);
      flt = 0;
      clear_mon();
      start_a();
      wait_done("t4_done_seen");
      repeat (5) @(negedge clk);
      check("t4_strobes", n_cs, 32'd80);
      check("t4_e0_addr", 32'(seq(0, 1)), 32'o01326754);
      check("t4_fail", 32'(fail), 32'd0);

      // 5: start while busy and in the done cycle are both ignored
      clear_mon();
      start_a();
      repeat (60) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done("t5_done_seen");
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (40) @(negedge clk);
      check("t5_done_cnt", n_done, 32'd1);
      check("t5_strobes", n_cs, 32'd80);
      check("t5_idle", 32'({busy, bus_a.cnt_en}), 32'd0);

      // 6: address 0 always reads 0xFF, one-bit fail counter
      begin
         bit seen_b;
         seen_b = 1'b0;
         @(negedge clk); start_b = 1'b1;
         @(negedge clk); start_b = 1'b0;
         for (int i = 0; i < 3000 && !seen_b; i++) begin
            @(negedge clk);
            if (done_b) seen_b = 1'b1;
         end
         check("t6_done_seen", 32'(seen_b), 32'd1);
      end
      @(negedge clk);
      check("t6_fail", 32'(fail_b), 32'd1);
      check("t6_fail_addr", 32'(fail_addr_b), 32'd0);
      check("t6_fail_elem", 32'(fail_elem_b), 32'd1);
      check("t6_fail_cnt", 32'(fail_cnt_b), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
